calc_seq: RTL and testbench
===========================

Name: calc_seq

Overview:
Parametrised sequential calculator, successor to the fixed 8-bit calculator. Supports operand width WIDTH and four modes: add, subtract, multiply, left shift. Multiply is an iterative shift-add over WIDTH cycles. The block uses a start/busy/done handshake so a controller or bench can issue back-to-back operations. It sits between the operand registers/controller and the result bus.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2 or more.
- SHW (localparam), $clog2(WIDTH), number of shift-amount bits taken from b.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enb  in  1  clock enable; when 0, all state holds.
- start  in  1  operation request; sampled only in IDLE.
- modo  in  2  operation select: 00 add, 01 sub, 10 mul, 11 shl.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c  out  WIDTH  registered result; holds the last completed result.
- busy  out  1  high while in EXEC.
- done  out  1  high for exactly one cycle while in DONE.

Behaviour:
- Reset:
  - rst low asynchronously forces state=IDLE and c=0; busy, done, counter and operand latches are also cleared to 0.
  - Release of rst is synchronous to clk.
- States: IDLE, EXEC, DONE. busy and done are decoded from the state register (busy = EXEC, done = DONE).
- IDLE:
  - With enb=1 and start=1 at edge k: latch a, b and modo; clear the counter; go to EXEC.
  - With start=0: stay in IDLE.
- EXEC for add, sub and shl:
  - Lasts one cycle.
  - At edge k+1: write the result to c; go to DONE.
- EXEC for mul:
  - Shift-add over WIDTH cycles; the counter runs 0 to WIDTH-1.
  - At edge k+WIDTH: c receives the low WIDTH bits of the product; go to DONE.
- DONE: lasts one cycle, then returns unconditionally to IDLE. Earliest next accepted start is at the edge where DONE exits to IDLE plus one, i.e. back-to-back issue costs one idle cycle.
- Arithmetic:
  - add: (a+b) mod 2^WIDTH.
  - sub: (a-b) mod 2^WIDTH, wraps (two's complement).
  - mul: low WIDTH bits of a*b; upper bits are discarded.
  - shl: a << b. The shift amount is the full value of b. If b ≥ WIDTH, the result is 0.
- Boundaries:
  - start while in EXEC or DONE is ignored, not queued.
  - Operand or modo changes during EXEC have no effect, because the latched copies are used.
  - enb=0 mid-operation freezes state, counter and partial product; execution resumes when enb returns to 1; c and flags hold throughout.
  - rst low mid-multiply aborts immediately: c=0, IDLE, and no done pulse.
  - c changes only on the edge entering DONE.

Optional Feature:
- Macro: CALC_FLAGS_EN.
- When defined, add output ports zero (1) and carry (1). Both are registered with c on the edge entering DONE and reset to 0.
  - zero = (result == 0).
  - carry means:
    - add: carry-out.
    - sub: borrow (a < b, unsigned).
    - mul: any nonzero discarded high product bit.
    - shl: any 1 bit shifted out, or b ≥ WIDTH with a ≠ 0.
- When not defined, the ports and flag logic are absent; all other behaviour is identical.

Decomposition:
- Package calc_pkg holds:
  - modo encodings MODO_ADD, MODO_SUB, MODO_MUL, MODO_SHL;
  - FSM state encodings ST_IDLE, ST_EXEC, ST_DONE.
- One sub-module: calc_mul_seq, the iterative shift-add multiplier. Its interface is clk/rst/enb, load, a, b, finish, product_lo and product_hi; product_hi feeds the mul carry flag.
- The top level holds the FSM, the operand latches and the single-cycle datapath.

Test Plan (WIDTH=8, CALC_FLAGS_EN defined):
- add: start at edge k with 1+1 gives c=2, done high for one cycle after edge k+1. Then 9+6 gives c=15 with carry=0. Then 200+100 gives c=44 with carry=1.
- sub: 3-1 gives c=2. 25-5 gives c=20. 1-3 gives c=0xFE with carry=1. 5-5 gives c=0 with zero=1.
- mul: 9*17 gives c=153 (0x99); busy is high for 8 cycles and done follows at edge k+8. 20*20 gives c=0x90 with carry=1. 0*255 gives c=0 with zero=1.
- shl: 8<<2 gives c=32. 1<<7 gives c=0x80 with carry=0. 0x81<<1 gives c=0x02 with carry=1. 1<<9 gives c=0.
- Handshake: start pulsed during mul EXEC is ignored, and only one done occurs. enb=0 for 3 cycles mid-mul delays done by exactly 3 cycles with the correct result.
- Reset: rst low at cycle 4 of a mul gives immediately c=0, busy=0 and no done pulse. A new add after reset release completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings for the calc_seq sequential calculator: operation select and FSM states.
package calc_pkg;

  localparam logic [1:0] MODO_ADD = 2'b00;
  localparam logic [1:0] MODO_SUB = 2'b01;
  localparam logic [1:0] MODO_MUL = 2'b10;
  localparam logic [1:0] MODO_SHL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/calc_mul_seq.sv
// Iterative shift-add multiplier: one partial product per enabled cycle, WIDTH cycles per product.
// product_lo/product_hi show the accumulator including the current step, valid while finish is high.
module calc_mul_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             finish,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic                 r_active;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;

  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_accNext;

  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_accNext  = r_acc + w_addend;
  assign finish     = r_active && (r_cnt == LAST);
  assign product_lo = w_accNext[WIDTH-1:0];
  assign product_hi = w_accNext[2*WIDTH-1:WIDTH];

  // The final step is folded into the outputs so the caller can capture the product on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (enb) begin
      if (load) begin
        r_active <= 1'b1;
        r_cnt    <= '0;
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, a};
        r_mplier <= b;
      end else if (r_active) begin
        r_acc    <= w_accNext;
        r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
        if (finish) begin
          r_active <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/calc_seq.sv
// Parametrised sequential calculator (add/sub/mul/shl) with start/busy/done handshake.
// Optional zero/carry flag outputs are enabled by defining CALC_FLAGS_EN.
module calc_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             start,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done
`ifdef CALC_FLAGS_EN
  ,
  output logic             zero,
  output logic             carry
`endif
);

  localparam int SHW = $clog2(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_modo;
  logic [WIDTH-1:0] r_c;

  logic             w_accept;
  logic             w_mulLoad;
  logic             w_mulFinish;
  logic             w_complete;
  logic [WIDTH-1:0] w_prodLo;
  logic [WIDTH-1:0] w_prodHi;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_shOver;
  logic [WIDTH-1:0] w_shlRes;
  logic [WIDTH-1:0] w_shlBack;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;

  assign c    = r_c;
  assign busy = (r_state == ST_EXEC);
  assign done = (r_state == ST_DONE);

  assign w_accept   = enb && start && (r_state == ST_IDLE);
  assign w_mulLoad  = w_accept && (modo == MODO_MUL);
  assign w_complete = (r_state == ST_EXEC) && ((r_modo != MODO_MUL) || w_mulFinish);

  calc_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .load      (w_mulLoad),
    .a         (a),
    .b         (b),
    .finish    (w_mulFinish),
    .product_lo(w_prodLo),
    .product_hi(w_prodHi)
  );

  // Any b bit above the low SHW bits means b >= WIDTH, so everything is shifted out.
  always_comb begin
    w_sum     = {1'b0, r_a} + {1'b0, r_b};
    w_diff    = {1'b0, r_a} - {1'b0, r_b};
    w_shOver  = |(r_b >> SHW);
    w_shlRes  = w_shOver ? '0 : (r_a << r_b[SHW-1:0]);
    w_shlBack = w_shlRes >> r_b[SHW-1:0];
    w_res     = '0;
    w_carry   = 1'b0;
    case (r_modo)
      MODO_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      MODO_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
      end
      MODO_MUL: begin
        w_res   = w_prodLo;
        w_carry = |w_prodHi;
      end
      default: begin
        w_res   = w_shlRes;
        w_carry = w_shOver ? (|r_a) : (w_shlBack != r_a);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_modo  <= MODO_ADD;
      r_c     <= '0;
    end else if (enb) begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_modo  <= modo;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_complete) begin
            r_c     <= w_res;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef CALC_FLAGS_EN
  logic r_zero;
  logic r_carry;

  assign zero  = r_zero;
  assign carry = r_carry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (enb && w_complete) begin
      r_zero  <= (w_res == '0);
      r_carry <= w_carry;
    end
  end
`else
  logic w_unusedFlags;
  assign w_unusedFlags = w_carry ^ w_accept;
`endif

endmodule

// File: tb/tb_calc_seq.sv
// Self-checking bench for calc_seq (WIDTH=8): vector table plus handshake, enable and reset sequences.
module tb_calc_seq;
  import calc_pkg::*;

  localparam int WIDTH = 8;
  localparam int NVEC  = 16;

  typedef struct {
    logic [1:0] modo;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expC;
    logic       expZero;
    logic       expCarry;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       start;
  logic [1:0] modo;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] c;
  logic       busy;
  logic       done;
`ifdef CALC_FLAGS_EN
  logic       zero;
  logic       carry;
`endif

  int   nChecks = 0;
  int   nFails  = 0;
  vec_t vecs[NVEC];

  calc_seq #(
    .WIDTH(WIDTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .enb  (enb),
    .start(start),
    .modo (modo),
    .a    (a),
    .b    (b),
    .c    (c),
    .busy (busy),
    .done (done)
`ifdef CALC_FLAGS_EN
    ,
    .zero (zero),
    .carry(carry)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issue one start pulse, then scramble the inputs so only the latched copies can be used.
  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    modo  = m;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    modo  = ~m;
    a     = ~av;
    b     = bv + 8'd3;
  endtask

  task automatic runVector(input vec_t v, input string name);
    int busyCycles;
    int expBusy;
    expBusy = (v.modo == MODO_MUL) ? WIDTH : 1;
    applyStimulus(v.modo, v.a, v.b);
    busyCycles = 0;
    while (busy && busyCycles < 64) begin
      busyCycles++;
      @(negedge clk);
    end
    checkOutput({name, ".busyCycles"}, 32'(busyCycles), 32'(expBusy));
    checkOutput({name, ".done"}, 32'(done), 32'd1);
    checkOutput({name, ".c"}, 32'(c), 32'(v.expC));
`ifdef CALC_FLAGS_EN
    checkOutput({name, ".zero"}, 32'(zero), 32'(v.expZero));
    checkOutput({name, ".carry"}, 32'(carry), 32'(v.expCarry));
`endif
    @(negedge clk);
    checkOutput({name, ".donePulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int busyCount;
    int doneCount;
    vec_t postReset;

    vecs[0]  = '{MODO_ADD, 8'd1,   8'd1,   8'd2,    1'b0, 1'b0};
    vecs[1]  = '{MODO_ADD, 8'd9,   8'd6,   8'd15,   1'b0, 1'b0};
    vecs[2]  = '{MODO_ADD, 8'd200, 8'd100, 8'd44,   1'b0, 1'b1};
    vecs[3]  = '{MODO_ADD, 8'd255, 8'd1,   8'd0,    1'b1, 1'b1};
    vecs[4]  = '{MODO_SUB, 8'd3,   8'd1,   8'd2,    1'b0, 1'b0};
    vecs[5]  = '{MODO_SUB, 8'd25,  8'd5,   8'd20,   1'b0, 1'b0};
    vecs[6]  = '{MODO_SUB, 8'd1,   8'd3,   8'hFE,   1'b0, 1'b1};
    vecs[7]  = '{MODO_SUB, 8'd5,   8'd5,   8'd0,    1'b1, 1'b0};
    vecs[8]  = '{MODO_MUL, 8'd9,   8'd17,  8'h99,   1'b0, 1'b0};
    vecs[9]  = '{MODO_MUL, 8'd20,  8'd20,  8'h90,   1'b0, 1'b1};
    vecs[10] = '{MODO_MUL, 8'd0,   8'd255, 8'd0,    1'b1, 1'b0};
    vecs[11] = '{MODO_SHL, 8'd8,   8'd2,   8'd32,   1'b0, 1'b0};
    vecs[12] = '{MODO_SHL, 8'd1,   8'd7,   8'h80,   1'b0, 1'b0};
    vecs[13] = '{MODO_SHL, 8'h81,  8'd1,   8'h02,   1'b0, 1'b1};
    vecs[14] = '{MODO_SHL, 8'd1,   8'd9,   8'd0,    1'b1, 1'b1};
    vecs[15] = '{MODO_SHL, 8'd0,   8'd9,   8'd0,    1'b1, 1'b0};
    postReset = '{MODO_ADD, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0};

    rst   = 1'b0;
    enb   = 1'b1;
    start = 1'b0;
    modo  = MODO_ADD;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset.c", 32'(c), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
`ifdef CALC_FLAGS_EN
    checkOutput("reset.zero", 32'(zero), 32'd0);
    checkOutput("reset.carry", 32'(carry), 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
    end

    // A start pulse during a multiply must be dropped, not queued behind it.
    applyStimulus(MODO_MUL, 8'd9, 8'd17);
    busyCount = 0;
    doneCount = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 2) begin
        start = 1'b1;
        modo  = MODO_ADD;
        a     = 8'd1;
        b     = 8'd1;
      end
      if (i == 3) start = 1'b0;
      if (busy) busyCount++;
      if (done) doneCount++;
      @(negedge clk);
    end
    checkOutput("ignoreStart.busyCycles", 32'(busyCount), 32'd8);
    checkOutput("ignoreStart.doneCount", 32'(doneCount), 32'd1);
    checkOutput("ignoreStart.c", 32'(c), 32'h99);

    // Three disabled cycles mid-multiply stretch the operation by exactly three cycles.
    applyStimulus(MODO_MUL, 8'd20, 8'd20);
    busyCount = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (busy) busyCount++;
      enb = !(i >= 3 && i < 6);
      if (i >= 3 && i < 6) begin
        checkOutput($sformatf("freeze%0d.c", i), 32'(c), 32'h99);
      end
      @(negedge clk);
    end
    enb = 1'b1;
    checkOutput("freeze.busyCycles", 32'(busyCount), 32'd11);
    checkOutput("freeze.done", 32'(done), 32'd1);
    checkOutput("freeze.c", 32'(c), 32'h90);
    @(negedge clk);
    checkOutput("freeze.donePulse", 32'(done), 32'd0);

    // Reset in the middle of a multiply aborts it with no done pulse.
    applyStimulus(MODO_MUL, 8'd9, 8'd17);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort.c", 32'(c), 32'd0);
    checkOutput("abort.busy", 32'(busy), 32'd0);
    checkOutput("abort.done", 32'(done), 32'd0);
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b1;
      if (done) doneCount++;
    end
    checkOutput("abort.doneCount", 32'(doneCount), 32'd0);
    checkOutput("abort.idleBusy", 32'(busy), 32'd0);
    checkOutput("abort.cHeld", 32'(c), 32'd0);

    runVector(postReset, "postReset");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
